// File: rtl/map_table_ckpt.sv
// -----------------------------------------------------------------------------
// map_table_ckpt
//
// Rename map table with RENAME_WIDTH rename slots per cycle. Later slots in a
// group see the destinations written by earlier slots of the same group. A
// circular stack of NUM_CKPT table snapshots lets branch recovery restore the
// whole map in one cycle, selected by checkpoint tag.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   rs1_arch/rs2_arch source architectural registers per slot
//   rs1_phys/rs2_phys mapped physical sources per slot (combinational)
//   wr_en             slot writes a destination
//   rd_arch, rd_phys  destination arch register and its new physical register
//   rd_phys_old       previous mapping of rd_arch (for the ROB)
//   ckpt_req          group contains a branch that needs a checkpoint
//   ckpt_slot         slot index of that branch
//   ckpt_ack, ckpt_tag  checkpoint accepted this cycle and its tag
//   ckpt_full, ckpt_count  checkpoint stack occupancy
//   resolve_en        oldest branch resolved correctly, free the head entry
//   mispredict_en, mispredict_tag  restore the table from a checkpoint
// -----------------------------------------------------------------------------
module map_table_ckpt #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int PHYS_REG_BITS = 7,
    parameter int RENAME_WIDTH  = 2,
    parameter int NUM_CKPT      = 4,
    parameter int CKPT_BITS     = $clog2(NUM_CKPT),
    parameter int SLOT_BITS     = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [RENAME_WIDTH-1:0][4:0]                rs1_arch,
    input  logic [RENAME_WIDTH-1:0][4:0]                rs2_arch,
    output logic [RENAME_WIDTH-1:0][PHYS_REG_BITS-1:0]  rs1_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_REG_BITS-1:0]  rs2_phys,
    input  logic [RENAME_WIDTH-1:0]                     wr_en,
    input  logic [RENAME_WIDTH-1:0][4:0]                rd_arch,
    input  logic [RENAME_WIDTH-1:0][PHYS_REG_BITS-1:0]  rd_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_REG_BITS-1:0]  rd_phys_old,
    input  logic                                        ckpt_req,
    input  logic [SLOT_BITS-1:0]                        ckpt_slot,
    output logic                                        ckpt_ack,
    output logic [CKPT_BITS-1:0]                        ckpt_tag,
    output logic                                        ckpt_full,
    output logic [CKPT_BITS:0]                          ckpt_count,
    input  logic                                        resolve_en,
    input  logic                                        mispredict_en,
    input  logic [CKPT_BITS-1:0]                        mispredict_tag
);

    localparam int CNT_BITS = CKPT_BITS + 1;

    // Architectural-to-physical map and its checkpoint snapshots
    logic [PHYS_REG_BITS-1:0] map_q  [NUM_ARCH_REGS];
    logic [PHYS_REG_BITS-1:0] map_d  [NUM_ARCH_REGS];
    logic [PHYS_REG_BITS-1:0] ckpt_q [NUM_CKPT][NUM_ARCH_REGS];
    logic [PHYS_REG_BITS-1:0] snap_s [NUM_ARCH_REGS];

    // Checkpoint stack pointers and occupancy
    logic [CKPT_BITS-1:0] head_q, head_d;
    logic [CKPT_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0]  count_q, count_d;

    logic                 full_s;
    logic                 alloc_s;
    logic                 stall_s;
    logic                 res_ok_s;
    logic [CKPT_BITS-1:0] dist_s;
    logic [RENAME_WIDTH-1:0] wr_eff_s;

    // Mapping seen by slot `slot` for register q: the newest earlier slot in
    // the group that writes q wins over the stored table entry; x0 is pinned.
    function automatic logic [PHYS_REG_BITS-1:0] lookup_f(
        input logic [4:0]                                  q,
        input int                                          slot,
        input logic [PHYS_REG_BITS-1:0]                    base,
        input logic [RENAME_WIDTH-1:0]                     we,
        input logic [RENAME_WIDTH-1:0][4:0]                ra,
        input logic [RENAME_WIDTH-1:0][PHYS_REG_BITS-1:0]  rp
    );
        logic [PHYS_REG_BITS-1:0] r;
        r = base;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            r = ((j < slot) && we[j] && (ra[j] == q)) ? rp[j] : r;
        end
        return (q == 5'd0) ? {PHYS_REG_BITS{1'b0}} : r;
    endfunction

    // Occupancy status and group acceptance decisions
    assign full_s   = (count_q == CNT_BITS'(NUM_CKPT));
    assign alloc_s  = ckpt_req & ~full_s & ~mispredict_en;
    // A branch that cannot get a checkpoint holds the whole group upstream.
    assign stall_s  = ckpt_req & (full_s | mispredict_en);
    assign res_ok_s = resolve_en & (count_q != CNT_BITS'(0));
    // Live entries from head up to the restored tag, modulo the stack size.
    assign dist_s   = mispredict_tag - head_q;

    assign ckpt_ack   = alloc_s;
    assign ckpt_tag   = tail_q;
    assign ckpt_full  = full_s;
    assign ckpt_count = count_q;

    // Combinational source and old-destination lookups with intra-group bypass
    always_comb begin
        rs1_phys    = '0;
        rs2_phys    = '0;
        rd_phys_old = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            rs1_phys[i]    = lookup_f(rs1_arch[i], i, map_q[rs1_arch[i]], wr_en, rd_arch, rd_phys);
            rs2_phys[i]    = lookup_f(rs2_arch[i], i, map_q[rs2_arch[i]], wr_en, rd_arch, rd_phys);
            rd_phys_old[i] = lookup_f(rd_arch[i],  i, map_q[rd_arch[i]],  wr_en, rd_arch, rd_phys);
        end
    end

    // Slot writes that actually commit: x0, stalled groups and recovery cycles drop them
    always_comb begin
        wr_eff_s = '0;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            wr_eff_s[j] = wr_en[j] & (rd_arch[j] != 5'd0) & ~stall_s & ~mispredict_en;
        end
    end

    // Snapshot for a new checkpoint: table plus writes of slots up to the branch
    always_comb begin
        snap_s = map_q;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            snap_s[rd_arch[j]] = ((j <= int'(ckpt_slot)) && wr_en[j] && (rd_arch[j] != 5'd0))
                               ? rd_phys[j] : snap_s[rd_arch[j]];
        end
    end

    // Next table: a restore overrides all writes; otherwise the highest slot wins
    always_comb begin
        map_d = map_q;
        if (mispredict_en) begin
            map_d = ckpt_q[mispredict_tag];
        end else begin
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                map_d[rd_arch[j]] = wr_eff_s[j] ? rd_phys[j] : map_d[rd_arch[j]];
            end
        end
    end

    // Next checkpoint pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict_en) begin
            // The restored checkpoint stays live until its branch resolves.
            tail_d = mispredict_tag + CKPT_BITS'(1);
            if (res_ok_s && (mispredict_tag != head_q)) begin
                head_d  = head_q + CKPT_BITS'(1);
                count_d = {1'b0, dist_s};
            end else begin
                head_d  = head_q;
                count_d = {1'b0, dist_s} + CNT_BITS'(1);
            end
        end else begin
            if (alloc_s) begin
                tail_d = tail_q + CKPT_BITS'(1);
            end else begin
                tail_d = tail_q;
            end
            if (res_ok_s) begin
                head_d = head_q + CKPT_BITS'(1);
            end else begin
                head_d = head_q;
            end
            case ({alloc_s, res_ok_s})
                2'b10:   count_d = count_q + CNT_BITS'(1);
                2'b01:   count_d = count_q - CNT_BITS'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Map table register; reset to the identity mapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= PHYS_REG_BITS'(i);
            end
        end else begin
            map_q <= map_d;
        end
    end

    // Checkpoint storage; an entry is written at the tail when allocated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CKPT; k++) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                    ckpt_q[k][i] <= PHYS_REG_BITS'(i);
                end
            end
        end else if (alloc_s) begin
            ckpt_q[tail_q] <= snap_s;
        end else begin
            ckpt_q <= ckpt_q;
        end
    end

    // Checkpoint pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_map_table_ckpt.sv
module tb_map_table_ckpt;

    localparam int RW = 2;
    localparam int P  = 7;
    localparam int CB = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [RW-1:0][4:0]       rs1_arch, rs2_arch, rd_arch;
    logic [RW-1:0][P-1:0]     rs1_phys, rs2_phys, rd_phys, rd_phys_old;
    logic [RW-1:0]            wr_en;
    logic                     ckpt_req;
    logic [0:0]               ckpt_slot;
    logic                     ckpt_ack;
    logic [CB-1:0]            ckpt_tag;
    logic                     ckpt_full;
    logic [CB:0]              ckpt_count;
    logic                     resolve_en;
    logic                     mispredict_en;
    logic [CB-1:0]            mispredict_tag;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    map_table_ckpt dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1_arch       (rs1_arch),
        .rs2_arch       (rs2_arch),
        .rs1_phys       (rs1_phys),
        .rs2_phys       (rs2_phys),
        .wr_en          (wr_en),
        .rd_arch        (rd_arch),
        .rd_phys        (rd_phys),
        .rd_phys_old    (rd_phys_old),
        .ckpt_req       (ckpt_req),
        .ckpt_slot      (ckpt_slot),
        .ckpt_ack       (ckpt_ack),
        .ckpt_tag       (ckpt_tag),
        .ckpt_full      (ckpt_full),
        .ckpt_count     (ckpt_count),
        .resolve_en     (resolve_en),
        .mispredict_en  (mispredict_en),
        .mispredict_tag (mispredict_tag)
    );

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed %0d expected <queued entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic clear_inputs();
        rs1_arch       = '0;
        rs2_arch       = '0;
        rd_arch        = '0;
        rd_phys        = '0;
        wr_en          = '0;
        ckpt_req       = 1'b0;
        ckpt_slot      = 1'b0;
        resolve_en     = 1'b0;
        mispredict_en  = 1'b0;
        mispredict_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        tick();
        clear_inputs();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        push("rst_count", 0);
        push("rst_full", 0);
        push("rst_ack", 0);
        pop_chk(32'(ckpt_count));
        pop_chk(32'(ckpt_full));
        pop_chk(32'(ckpt_ack));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: identity sweep after reset
        for (int i = 0; i < 32; i++) begin
            tick();
            rs1_arch[0] = 5'(i);
            push("sweep_rs1", i);
            #2;
            pop_chk(32'(rs1_phys[0]));
        end
        push("idle_count", 0);
        push("idle_full", 0);
        pop_chk(32'(ckpt_count));
        pop_chk(32'(ckpt_full));

        // 2: intra-group bypass on x1
        tick();
        clear_inputs();
        wr_en = 2'b11;
        rd_arch[0] = 5'd1; rd_phys[0] = 7'd40;
        rd_arch[1] = 5'd1; rd_phys[1] = 7'd41;
        rs1_arch[1] = 5'd1;
        push("byp_rs1_s1", 40);
        push("byp_old_s1", 40);
        push("byp_old_s0", 1);
        push("x1_after", 41);
        #2;
        pop_chk(32'(rs1_phys[1]));
        pop_chk(32'(rd_phys_old[1]));
        pop_chk(32'(rd_phys_old[0]));
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd1;
        #2;
        pop_chk(32'(rs1_phys[0]));

        // 3: checkpoint at slot 0, then restore
        tick();
        clear_inputs();
        wr_en = 2'b11;
        rd_arch[0] = 5'd2; rd_phys[0] = 7'd50;
        rd_arch[1] = 5'd3; rd_phys[1] = 7'd51;
        ckpt_req = 1'b1;
        ckpt_slot = 1'b0;
        push("t3_ack", 1);
        push("t3_tag", 0);
        #2;
        pop_chk(32'(ckpt_ack));
        pop_chk(32'(ckpt_tag));
        tick();
        clear_inputs();
        wr_en = 2'b01;
        rd_arch[0] = 5'd2; rd_phys[0] = 7'd60;
        mispredict_en = 1'b1;
        mispredict_tag = 2'd0;
        rs1_arch[1] = 5'd3;
        push("t3_x3_pre", 51);
        push("t3_x2_rest", 50);
        push("t3_x3_rest", 3);
        push("t3_count", 1);
        #2;
        pop_chk(32'(rs1_phys[1]));
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd2;
        rs2_arch[0] = 5'd3;
        #2;
        pop_chk(32'(rs1_phys[0]));
        pop_chk(32'(rs2_phys[0]));
        pop_chk(32'(ckpt_count));

        // 4: fill the stack, refused requests, wrap-around retry
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            tick();
            clear_inputs();
            ckpt_req = 1'b1;
            push("fill_ack", 1);
            push("fill_tag", k);
            #2;
            pop_chk(32'(ckpt_ack));
            pop_chk(32'(ckpt_tag));
        end
        tick();
        clear_inputs();
        push("full_flag", 1);
        push("full_count", 4);
        push("full_ack", 0);
        ckpt_req = 1'b1;
        wr_en = 2'b01;
        rd_arch[0] = 5'd5; rd_phys[0] = 7'd70;
        #2;
        pop_chk(32'(ckpt_full));
        pop_chk(32'(ckpt_count));
        pop_chk(32'(ckpt_ack));
        push("stall_x5", 5);
        push("stall_count", 4);
        push("full_res_ack", 0);
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd5;
        #2;
        pop_chk(32'(rs1_phys[0]));
        pop_chk(32'(ckpt_count));
        ckpt_req = 1'b1;
        wr_en = 2'b01;
        rd_arch[0] = 5'd5; rd_phys[0] = 7'd70;
        resolve_en = 1'b1;
        #1;
        pop_chk(32'(ckpt_ack));
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd5;
        ckpt_req = 1'b1;
        wr_en = 2'b01;
        rd_arch[0] = 5'd5; rd_phys[0] = 7'd70;
        push("res_count", 3);
        push("res_full", 0);
        push("retry_ack", 1);
        push("retry_tag", 0);
        push("retry_x5_pre", 5);
        push("wrap_x5", 70);
        push("wrap_count", 4);
        push("wrap_full", 1);
        #2;
        pop_chk(32'(ckpt_count));
        pop_chk(32'(ckpt_full));
        pop_chk(32'(ckpt_ack));
        pop_chk(32'(ckpt_tag));
        pop_chk(32'(rs1_phys[0]));
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd5;
        #2;
        pop_chk(32'(rs1_phys[0]));
        pop_chk(32'(ckpt_count));
        pop_chk(32'(ckpt_full));

        // 5: same-destination writes and x0
        tick();
        clear_inputs();
        wr_en = 2'b11;
        rd_arch[0] = 5'd7; rd_phys[0] = 7'd80;
        rd_arch[1] = 5'd7; rd_phys[1] = 7'd81;
        push("x7_old_s1", 80);
        push("x7_old_s0", 7);
        push("x7_winner", 81);
        #2;
        pop_chk(32'(rd_phys_old[1]));
        pop_chk(32'(rd_phys_old[0]));
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd7;
        #2;
        pop_chk(32'(rs1_phys[0]));
        tick();
        clear_inputs();
        wr_en = 2'b01;
        rd_arch[0] = 5'd0; rd_phys[0] = 7'd99;
        rs1_arch[1] = 5'd0;
        rs2_arch[1] = 5'd7;
        push("x0_bypass", 0);
        push("x7_s1", 81);
        push("x0_after", 0);
        #2;
        pop_chk(32'(rs1_phys[1]));
        pop_chk(32'(rs2_phys[1]));
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd0;
        #2;
        pop_chk(32'(rs1_phys[0]));

        // 6: restore with concurrent resolve, then asynchronous reset
        reset_pulse();
        tick();
        clear_inputs();
        ckpt_req = 1'b1;
        wr_en = 2'b01;
        rd_arch[0] = 5'd10; rd_phys[0] = 7'd20;
        push("c0_ack", 1);
        push("c0_tag", 0);
        #2;
        pop_chk(32'(ckpt_ack));
        pop_chk(32'(ckpt_tag));
        tick();
        clear_inputs();
        ckpt_req = 1'b1;
        wr_en = 2'b11;
        rd_arch[0] = 5'd11; rd_phys[0] = 7'd21;
        rd_arch[1] = 5'd12; rd_phys[1] = 7'd22;
        push("c1_ack", 1);
        push("c1_tag", 1);
        #2;
        pop_chk(32'(ckpt_ack));
        pop_chk(32'(ckpt_tag));
        tick();
        clear_inputs();
        ckpt_req = 1'b1;
        rs1_arch[0] = 5'd12;
        push("c2_ack", 1);
        push("c2_tag", 2);
        push("c2_x12", 22);
        #2;
        pop_chk(32'(ckpt_ack));
        pop_chk(32'(ckpt_tag));
        pop_chk(32'(rs1_phys[0]));
        tick();
        clear_inputs();
        mispredict_en = 1'b1;
        mispredict_tag = 2'd1;
        resolve_en = 1'b1;
        ckpt_req = 1'b1;
        wr_en = 2'b01;
        rd_arch[0] = 5'd13; rd_phys[0] = 7'd23;
        push("mp_ack", 0);
        push("mp_count", 1);
        push("mp_x12", 12);
        push("mp_x11", 21);
        push("mp_x10", 20);
        push("mp_x13", 13);
        #2;
        pop_chk(32'(ckpt_ack));
        tick();
        clear_inputs();
        rs1_arch[0] = 5'd12;
        rs2_arch[0] = 5'd11;
        rs1_arch[1] = 5'd10;
        rs2_arch[1] = 5'd13;
        #2;
        pop_chk(32'(ckpt_count));
        pop_chk(32'(rs1_phys[0]));
        pop_chk(32'(rs2_phys[0]));
        pop_chk(32'(rs1_phys[1]));
        pop_chk(32'(rs2_phys[1]));
        tick();
        clear_inputs();
        ckpt_req = 1'b1;
        push("tail_ack", 1);
        push("tail_tag", 2);
        push("tail_count", 2);
        #2;
        pop_chk(32'(ckpt_ack));
        pop_chk(32'(ckpt_tag));
        tick();
        clear_inputs();
        #2;
        pop_chk(32'(ckpt_count));
        mispredict_en = 1'b1;
        mispredict_tag = 2'd2;
        push("head_count", 2);
        tick();
        clear_inputs();
        #2;
        pop_chk(32'(ckpt_count));
        rs1_arch[0] = 5'd10;
        rs2_arch[0] = 5'd12;
        push("pre_rst_x10", 20);
        push("arst_count", 0);
        push("arst_full", 0);
        push("arst_x10", 10);
        push("arst_x12", 12);
        #1;
        pop_chk(32'(rs1_phys[0]));
        rst_n = 1'b0;
        #1;
        pop_chk(32'(ckpt_count));
        pop_chk(32'(ckpt_full));
        pop_chk(32'(rs1_phys[0]));
        pop_chk(32'(rs2_phys[0]));
        #1 rst_n = 1'b1;
        tick();

        push("sb_drained", 0);
        pop_chk(32'(sb_q.size() - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
